// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, state encoding and funct helpers for the ALU control slice
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  localparam logic [1:0] ALUOP_LWSW = 2'b00;
  localparam logic [1:0] ALUOP_BEQ  = 2'b01;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic is_muldiv(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

  function automatic logic is_hilo(input logic [5:0] fn);
    return (fn == FN_MFHI) || (fn == FN_MFLO) || (fn == FN_MTHI) || (fn == FN_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_engine.sv
// rtl/muldiv_engine.sv - iterative shift-add multiplier / restoring divider with sign fix-up
module muldiv_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             start_div,
  input  logic             start_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             idle,
  output logic             busy,
  output logic             done,
  output logic             res_wr,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               is_signed;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic               neg_q;
  logic               neg_r;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign idle   = (state == ST_IDLE);
  assign res_wr = (state == ST_FIX);

  // Accumulator layout: MUL keeps {partial product, multiplier}; DIV keeps {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    neg_q     = is_signed && (sign_a ^ sign_b);
    neg_r     = is_signed && sign_a;
    prod_fix  = neg_q ? -acc : acc;
    q_fix     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      res_hi = r_fix;
      res_lo = b_zero ? '1 : q_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      b_zero    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc       <= {{WIDTH{1'b0}}, abs_val(op_a, start_signed)};
            opnd      <= abs_val(op_b, start_signed);
            is_div    <= start_div;
            is_signed <= start_signed;
            sign_a    <= op_a[WIDTH-1];
            sign_b    <= op_b[WIDTH-1];
            b_zero    <= (op_b == '0);
            cnt       <= CNT_W'(WIDTH);
            busy      <= 1'b1;
            state     <= start_div ? ST_DIV : ST_MUL;
          end
        end
        ST_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ST_FIX;
        end
        ST_DIV: begin
          if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else                  acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// rtl/alu_muldiv_ctrl.sv - ALU select decode, HI/LO registers and pipeline stall for mul/div
module alu_muldiv_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       fn_field,
  input  logic             issue,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       alu_ctrl,
  output logic             illegal,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  logic             rtype;
  logic             md_fn;
  logic             hl_fn;
  logic             start;
  logic             idle;
  logic             res_wr;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  assign rtype = alu_op[1];
  assign md_fn = rtype && is_muldiv(fn_field);
  assign hl_fn = rtype && is_hilo(fn_field);
  assign start = issue && md_fn && idle;
  // An issue of any HI/LO-touching op while the engine is working must re-present later.
  assign stall = busy || (issue && (md_fn || hl_fn) && !idle) || start;

  always_comb begin
    alu_ctrl = ALU_NONE;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_LWSW: alu_ctrl = ALU_ADD;
      ALUOP_BEQ:  alu_ctrl = ALU_SUB;
      default: begin
        case (fn_field)
          FN_ADD: alu_ctrl = ALU_ADD;
          FN_SUB: alu_ctrl = ALU_SUB;
          FN_AND: alu_ctrl = ALU_AND;
          FN_OR:  alu_ctrl = ALU_OR;
          FN_NOR: alu_ctrl = ALU_NOR;
          FN_SLT: alu_ctrl = ALU_SLT;
          default: illegal = !(is_muldiv(fn_field) || is_hilo(fn_field));
        endcase
      end
    endcase
  end

  always_comb begin
    hilo_out = '0;
    if (rtype && fn_field == FN_MFHI) hilo_out = hi;
    else if (rtype && fn_field == FN_MFLO) hilo_out = lo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (res_wr) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (issue && idle && rtype) begin
      if (fn_field == FN_MTHI) hi <= op_a;
      if (fn_field == FN_MTLO) lo <= op_a;
    end
  end

  muldiv_engine #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_engine (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_div   (fn_field[1]),
    .start_signed(!fn_field[0]),
    .op_a        (op_a),
    .op_b        (op_b),
    .idle        (idle),
    .busy        (busy),
    .done        (done),
    .res_wr      (res_wr),
    .res_hi      (res_hi),
    .res_lo      (res_lo)
  );

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb/tb_alu_muldiv_ctrl.sv - decode table sweep plus directed mul/div/HI-LO sequences
module tb_alu_muldiv_ctrl;

  localparam int W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   alu_op = 2'b00;
  logic [5:0]   fn_field = 6'b0;
  logic         issue = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [3:0]   alu_ctrl;
  logic         illegal;
  logic [W-1:0] hilo_out;
  logic         busy;
  logic         stall;
  logic         done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .alu_op  (alu_op),
    .fn_field(fn_field),
    .issue   (issue),
    .op_a    (op_a),
    .op_b    (op_b),
    .alu_ctrl(alu_ctrl),
    .illegal (illegal),
    .hilo_out(hilo_out),
    .busy    (busy),
    .stall   (stall),
    .done    (done)
  );

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
    logic       ill;
  } dec_t;

  dec_t dv[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
    alu_op = 2'b10;
    fn_field = F_MFHI;
    #1;
    chk({nm, " hi"}, hilo_out, eh);
    fn_field = F_MFLO;
    #1;
    chk({nm, " lo"}, hilo_out, el);
  endtask

  // Issues in the current cycle (cycle 0), walks to cycle W+3 and checks the result.
  task automatic run_op(input string nm, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int done_cyc = -1;
    int pulses = 0;
    int bad = 0;
    alu_op = 2'b10;
    fn_field = fn;
    op_a = a;
    op_b = b;
    issue = 1'b1;
    #1;
    if (stall !== 1'b1) bad++;
    step();
    issue = 1'b0;
    for (int c = 1; c <= W + 2; c++) begin
      if (stall !== 1'b1 || busy !== 1'b1) bad++;
      if (done === 1'b1) begin
        pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c < W + 2) step();
    end
    step();
    chk({nm, " done_cycle"}, done_cyc, W + 2);
    chk({nm, " done_pulses"}, pulses, 1);
    chk({nm, " stall_busy_gaps"}, bad, 0);
    chk({nm, " idle_busy"}, {31'b0, busy}, 0);
    chk({nm, " idle_stall"}, {31'b0, stall}, 0);
    read_hilo(nm, eh, el);
  endtask

  initial begin
    dv[0]  = '{2'b00, 6'b100010, 4'b0010, 1'b0};
    dv[1]  = '{2'b00, 6'b000111, 4'b0010, 1'b0};
    dv[2]  = '{2'b01, 6'b000111, 4'b0110, 1'b0};
    dv[3]  = '{2'b10, 6'b100000, 4'b0010, 1'b0};
    dv[4]  = '{2'b10, 6'b100010, 4'b0110, 1'b0};
    dv[5]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
    dv[6]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
    dv[7]  = '{2'b10, 6'b100111, 4'b1100, 1'b0};
    dv[8]  = '{2'b10, 6'b101010, 4'b0111, 1'b0};
    dv[9]  = '{2'b10, F_MULT,    4'b1111, 1'b0};
    dv[10] = '{2'b10, F_MULTU,   4'b1111, 1'b0};
    dv[11] = '{2'b10, F_DIV,     4'b1111, 1'b0};
    dv[12] = '{2'b10, F_DIVU,    4'b1111, 1'b0};
    dv[13] = '{2'b10, F_MFHI,    4'b1111, 1'b0};
    dv[14] = '{2'b10, F_MFLO,    4'b1111, 1'b0};
    dv[15] = '{2'b10, F_MTHI,    4'b1111, 1'b0};
    dv[16] = '{2'b10, F_MTLO,    4'b1111, 1'b0};
    dv[17] = '{2'b10, 6'b000111, 4'b1111, 1'b1};
    dv[18] = '{2'b11, 6'b100010, 4'b0110, 1'b0};

    step();
    step();
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset stall", {31'b0, stall}, 0);
    read_hilo("reset", 32'h0, 32'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 19; i++) begin
      alu_op = dv[i].op;
      fn_field = dv[i].fn;
      #1;
      chk($sformatf("decode%0d ctrl", i), {28'b0, alu_ctrl}, {28'b0, dv[i].ctrl});
      chk($sformatf("decode%0d illegal", i), {31'b0, illegal}, {31'b0, dv[i].ill});
    end
    step();

    run_op("mult", F_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", F_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", F_DIVU, 32'h0000_0007, 32'h0, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_zero_s", F_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // mthi: single cycle, no stall, readable next cycle
    alu_op = 2'b10;
    fn_field = F_MTHI;
    op_a = 32'h0000_1234;
    issue = 1'b1;
    #1;
    chk("mthi stall", {31'b0, stall}, 0);
    step();
    issue = 1'b0;
    fn_field = F_MFHI;
    #1;
    chk("mthi->mfhi", hilo_out, 32'h0000_1234);
    chk("mthi busy", {31'b0, busy}, 0);
    fn_field = F_MTLO;
    op_a = 32'hCAFE_0001;
    issue = 1'b1;
    step();
    issue = 1'b0;
    read_hilo("mtlo", 32'h0000_1234, 32'hCAFE_0001);

    // mfhi presented during an in-flight divu 100/7 stays stalled until after done
    begin
      int first_low = -1;
      fn_field = F_DIVU;
      op_a = 32'd100;
      op_b = 32'd7;
      issue = 1'b1;
      step();
      fn_field = F_MFHI;
      for (int c = 1; c <= W + 10; c++) begin
        if (stall === 1'b0) begin
          first_low = c;
          break;
        end
        step();
      end
      chk("mfhi stall release", first_low, W + 3);
      chk("mfhi after div", hilo_out, 32'd2);
      issue = 1'b0;
      fn_field = F_MFLO;
      #1;
      chk("mflo after div", hilo_out, 32'd14);
    end

    // reset in cycle 10 of a div aborts it
    begin
      int pulses = 0;
      fn_field = F_DIV;
      op_a = 32'h0000_0100;
      op_b = 32'd3;
      issue = 1'b1;
      step();
      issue = 1'b0;
      for (int c = 1; c < 10; c++) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort busy", {31'b0, busy}, 0);
      chk("abort stall", {31'b0, stall}, 0);
      read_hilo("abort", 32'h0, 32'h0);
      for (int c = 0; c < W + 6; c++) begin
        if (done === 1'b1) pulses++;
        step();
      end
      chk("abort no done", pulses, 0);
    end
    run_op("mult_after_rst", F_MULT, 32'd5, 32'd7, 32'h0, 32'd35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
